// File: rtl/cnt_round_ctrl.sv
// rtl/cnt_round_ctrl.sv - round-sequencing FSM driving the 8-bit event counter enable
// Optional pause input is built when CNT_ROUND_CTRL_PAUSE_EN is defined.
module cnt_round_ctrl #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             stop,
  input  logic [REP_W-1:0] rep_num,
  input  logic             cnt_end,
`ifdef CNT_ROUND_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             cnt_en,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic [REP_W-1:0] rep_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  state_t           state_q;
  logic             cnt_en_q;
  logic             busy_q;
  logic             done_q;
  logic             abort_q;
  logic [REP_W-1:0] rep_cnt_q;
  logic [REP_W-1:0] target_q;

  logic             evt;
  logic             run_en_d;
  logic [REP_W-1:0] rep_cnt_d;

  // A round only counts when the counter actually advances past 15.
  assign evt       = cnt_end & cnt_en_q;
  assign rep_cnt_d = rep_cnt_q + 1'b1;

`ifdef CNT_ROUND_CTRL_PAUSE_EN
  assign run_en_d = ~pause;
`else
  assign run_en_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      cnt_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      rep_cnt_q <= '0;
      target_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          abort_q  <= 1'b0;
          if (start) begin
            target_q  <= rep_num;
            rep_cnt_q <= '0;
            if (rep_num != '0) begin
              state_q  <= S_RUN;
              cnt_en_q <= 1'b1;
              busy_q   <= 1'b1;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          // stop wins over a coincident round event, which is then not tallied
          if (stop) begin
            state_q  <= S_ABORT;
            cnt_en_q <= 1'b0;
            busy_q   <= 1'b0;
            abort_q  <= 1'b1;
          end else if (evt && rep_cnt_d == target_q) begin
            rep_cnt_q <= rep_cnt_d;
            state_q   <= S_DONE;
            cnt_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            if (evt) rep_cnt_q <= rep_cnt_d;
            cnt_en_q <= run_en_d;
            busy_q   <= 1'b1;
          end
        end
        S_DONE, S_ABORT: begin
          state_q  <= S_IDLE;
          cnt_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          abort_q  <= 1'b0;
        end
        default: begin
          state_q  <= S_IDLE;
          cnt_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b0;
          abort_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en  = cnt_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign abort   = abort_q;
  assign rep_cnt = rep_cnt_q;

endmodule

// File: tb/tb_cnt_round_ctrl.sv
// tb/tb_cnt_round_ctrl.sv - randomized run/abort/reset bench for cnt_round_ctrl
// Exercises the pause path as well when CNT_ROUND_CTRL_PAUSE_EN is defined.
module tb_cnt_round_ctrl;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst_b = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [REP_W-1:0] rep_num = '0;
  logic             cnt_end;
  logic             cnt_en, busy, done, abort;
  logic [REP_W-1:0] rep_cnt;
`ifdef CNT_ROUND_CTRL_PAUSE_EN
  logic             pause = 1'b0;
`endif

  logic [7:0] cnt = 8'd0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  // Free-running 8-bit event counter the controller sits in front of.
  always @(posedge clk) begin
    if (load) cnt <= load_val;
    else if (cnt_en) cnt <= cnt + 8'd1;
  end
  assign cnt_end = (cnt == 8'd15);

  cnt_round_ctrl #(.REP_W(REP_W)) dut (
    .clk     (clk),
    .rst_b   (rst_b),
    .start   (start),
    .stop    (stop),
    .rep_num (rep_num),
    .cnt_end (cnt_end),
`ifdef CNT_ROUND_CTRL_PAUSE_EN
    .pause   (pause),
`endif
    .cnt_en  (cnt_en),
    .busy    (busy),
    .done    (done),
    .abort   (abort),
    .rep_cnt (rep_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // One run: counter preset to c0 on the start edge, n rounds, stop sampled at
  // edge offset s after the start edge (s<=0 means never). Expected behaviour is
  // derived from the edge offsets at which the counter passes 15.
  task automatic run(input int c0, input int n, input int s, input bit hold);
    int e[$];
    int last_e;
    int end_o;
    bit ab;
    int tally;
    for (int j = 0; j < n; j++) e.push_back(((15 - c0) & 255) + 1 + 256 * j);
    last_e = (n > 0) ? e[n-1] : 0;
    if (n == 0) begin
      end_o = 0; ab = 1'b0;
    end else if (s >= 1 && s <= last_e) begin
      end_o = s; ab = 1'b1;
    end else begin
      end_o = last_e; ab = 1'b0;
    end
    rep_num  = REP_W'(n);
    start    = 1'b1;
    stop     = 1'b0;
    load     = 1'b1;
    load_val = 8'(c0);
    @(posedge clk); #1;
    load  = 1'b0;
    start = hold && (end_o >= 1);
    for (int o = 0; o <= end_o + 1; o++) begin
      tally = 0;
      foreach (e[j]) if (e[j] <= o && (ab ? e[j] < end_o : e[j] <= end_o)) tally++;
      check("cnt_en", cnt_en, o < end_o);
      check("busy", busy, o < end_o);
      check("done", done, (o == end_o) && !ab);
      check("abort", abort, (o == end_o) && ab);
      check("rep_cnt", rep_cnt, tally);
      if (o == end_o && !ab && n != 0) check("parked", cnt, 16);
      stop  = (s >= 1) && (o + 1 == s);
      start = hold && (o + 1 <= end_o);
      @(posedge clk); #1;
    end
    stop  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int c0, n, s;
    bit hold;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cnt_en", cnt_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_abort", abort, 0);
    check("rst_rep_cnt", rep_cnt, 0);
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("idle_cnt_en", cnt_en, 0);

    run(0, 1, 0, 1'b0);
    run(0, 2, 0, 1'b0);
    run(37, 0, 0, 1'b0);
    run(0, 3, 272, 1'b0);
    run(15, 15, 0, 1'b1);

    // Asynchronous reset in the middle of a two-round run.
    rep_num  = 4'd2;
    start    = 1'b1;
    load     = 1'b1;
    load_val = 8'd0;
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    check("pre_rst_rep_cnt", rep_cnt, 1);
    rst_b = 1'b0;
    #1;
    check("arst_cnt_en", cnt_en, 0);
    check("arst_busy", busy, 0);
    check("arst_rep_cnt", rep_cnt, 0);
    check("arst_done", done, 0);
    check("arst_abort", abort, 0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    check("post_rst_done", done, 0);
    check("post_rst_abort", abort, 0);
    run(0, 2, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      c0   = int'($urandom_range(0, 255));
      n    = int'($urandom_range(0, 3));
      hold = 1'($urandom_range(0, 1));
      s    = 0;
      if (n > 0 && $urandom_range(0, 1) == 1) s = int'($urandom_range(1, 256 * n + 20));
      run(c0, n, s, hold);
    end

`ifdef CNT_ROUND_CTRL_PAUSE_EN
    // Pause sampled on edges 5..14 after start delays completion by 10 cycles.
    rep_num  = 4'd1;
    start    = 1'b1;
    load     = 1'b1;
    load_val = 8'd0;
    @(posedge clk); #1;
    load  = 1'b0;
    start = 1'b0;
    for (int o = 0; o <= 27; o++) begin
      check("pause_cnt_en", cnt_en, (o < 5) || (o >= 15 && o < 26));
      check("pause_busy", busy, o < 26);
      check("pause_done", done, o == 26);
      pause = (o + 1 >= 5) && (o + 1 <= 14);
      @(posedge clk); #1;
    end
    pause = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
